// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pin inputs and pause control in, clean game controls out.
// Latency: none; wires only.
// Backpressure: none; levels and single-cycle pulses, no handshake.
//
// Signals:
//   btn_raw     raw asynchronous button/switch inputs, polarity set by the conditioner
//   enable      synchronous pause control; 0 suppresses all pulses
//   btn_level   debounced level, 1 = pressed
//   btn_press   one-cycle pulse on a debounced press
//   btn_release one-cycle pulse on a debounced release
//   btn_repeat  one-cycle pulse on press and on every auto-repeat tick
//
// master: the side that owns the pins and consumes the controls (board glue / game core).
// slave : the conditioner itself.
interface button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic               enable;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        output enable,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        input  enable,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: polarity fix, 2-flop sync, debounce, edge pulses, auto-repeat.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from a stable raw change to btn_level/btn_press (+-1 for sampling phase).
// Backpressure: none; enable = 0 only masks pulses, debouncing keeps running and btn_level stays live.
//
// Ports:
//   clk_50   system clock
//   reset_n  asynchronous active-low reset, released synchronously by the clock edge
//   bus      button_conditioner_if.slave (btn_raw/enable in, btn_level/press/release/repeat out)
module button_conditioner #(
    parameter int                 NUM_BTN             = 4,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK     = 4'b1111,
    parameter logic [NUM_BTN-1:0] REPEAT_EN_MASK      = 4'b0111,
    parameter int                 DEBOUNCE_CYCLES     = 500000,
    parameter int                 REPEAT_DELAY_CYCLES = 15000000,
    parameter int                 REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic                clk_50,
    input  logic                reset_n,
    button_conditioner_if.slave bus
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX  = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int TW       = $clog2(RPT_MAX + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_CYCLES - 1);

    // ST_LOCKED: key is held but was pressed or paused while disabled; it stays
    // silent until released so that un-pausing never fires a stale press/repeat.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCKED = 2'd3
    } rep_state_t;

    logic [NUM_BTN-1:0] level_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;
    logic [NUM_BTN-1:0] repeat_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic          raw_n;
        logic          sync_meta;
        logic          sync_q;
        logic          level_q;
        logic [DW-1:0] db_cnt;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        logic          db_done;
        logic          press_ev;
        logic          release_ev;

        // Normalised so that 1 always means pressed, whatever the pin polarity.
        assign raw_n = bus.btn_raw[i] ^ ACTIVE_LOW_MASK[i];

        always_ff @(posedge clk_50 or negedge reset_n) begin
            if (!reset_n) begin
                sync_meta <= 1'b0;
                sync_q    <= 1'b0;
            end else begin
                sync_meta <= raw_n;
                sync_q    <= sync_meta;
            end
        end

        // The level flips on the edge where the synchronised input has disagreed
        // with it for DEBOUNCE_CYCLES consecutive samples. These are the events
        // that every pulse output keys off, so all pulses land on that same edge.
        assign db_done    = (sync_q != level_q) && (db_cnt == DB_LAST);
        assign press_ev   = db_done &&  sync_q;
        assign release_ev = db_done && !sync_q;

        always_ff @(posedge clk_50 or negedge reset_n) begin
            if (!reset_n) begin
                level_q   <= 1'b0;
                db_cnt    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if (sync_q == level_q) begin
                    // A single agreeing sample throws away any partial count.
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level_q <= sync_q;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
                press_q   <= press_ev   & bus.enable;
                release_q <= release_ev & bus.enable;
            end
        end

        if (REPEAT_EN_MASK[i]) begin : g_rep
            rep_state_t    state;
            logic [TW-1:0] rep_tmr;

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    state    <= ST_IDLE;
                    rep_tmr  <= '0;
                    repeat_q <= 1'b0;
                end else begin
                    repeat_q <= 1'b0;
                    // Release is checked first so it beats a repeat due on the same edge.
                    if (release_ev) begin
                        state   <= ST_IDLE;
                        rep_tmr <= '0;
                    end else begin
                        case (state)
                            ST_IDLE: begin
                                if (press_ev) begin
                                    rep_tmr <= '0;
                                    if (bus.enable) begin
                                        state    <= ST_DELAY;
                                        repeat_q <= 1'b1;
                                    end else begin
                                        state <= ST_LOCKED;
                                    end
                                end
                            end
                            ST_DELAY: begin
                                if (!bus.enable) begin
                                    state   <= ST_LOCKED;
                                    rep_tmr <= '0;
                                end else if (rep_tmr == DELAY_LAST) begin
                                    state    <= ST_REPEAT;
                                    rep_tmr  <= '0;
                                    repeat_q <= 1'b1;
                                end else begin
                                    rep_tmr <= rep_tmr + TW'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (!bus.enable) begin
                                    state   <= ST_LOCKED;
                                    rep_tmr <= '0;
                                end else if (rep_tmr == RATE_LAST) begin
                                    rep_tmr  <= '0;
                                    repeat_q <= 1'b1;
                                end else begin
                                    rep_tmr <= rep_tmr + TW'(1);
                                end
                            end
                            ST_LOCKED: begin
                                rep_tmr <= '0;
                            end
                            default: begin
                                state   <= ST_IDLE;
                                rep_tmr <= '0;
                            end
                        endcase
                    end
                end
            end
        end else begin : g_norep
            // Without auto-repeat the repeat stream is just the press pulse,
            // so consumers can listen to btn_repeat alone for every channel.
            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    repeat_q <= 1'b0;
                end else begin
                    repeat_q <= press_ev & bus.enable;
                end
            end
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
        assign repeat_v[i]  = repeat_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_repeat  = repeat_v;

endmodule
